memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_memory_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
// Pipeline MEM stage with a MEM/WB pipeline register.
//
// Behaviour:
// - Aligned memory instructions issue a data-memory request.
// - Execute and earlier stages are stalled until dmDone arrives or the wait
//   times out.
// - Misaligned accesses never reach memory. They pass straight through with
//   errOut set.
// - Once a halting instruction has reached MEM/WB, haltOut stays high and no
//   further memory requests are issued until reset.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   aluIn                execute result / memory address
//   storeData            store write data
//   setValIn, nextPcIn   execute side values forwarded to MEM/WB
//   memEnIn, memWrtIn    memory access request / write qualifier
//   regWrtIn, haltIn,
//   errIn                execute control bits
//   regWrtSrcIn,
//   writeRegIn           writeback source select / destination register
//   dmRdData, dmDone     data-memory read data and completion pulse
//   dmEn, dmWr,
//   dmAddr, dmWrData     data-memory request interface
//   stall                hold request to execute and earlier stages
//   aluOut .. writeRegOut  MEM/WB register outputs
// -----------------------------------------------------------------------------
module memory_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] aluIn,
  input  logic [15:0] storeData,
  input  logic [15:0] setValIn,
  input  logic [15:0] nextPcIn,
  input  logic        memEnIn,
  input  logic        memWrtIn,
  input  logic        regWrtIn,
  input  logic        haltIn,
  input  logic        errIn,
  input  logic [2:0]  regWrtSrcIn,
  input  logic [2:0]  writeRegIn,
  input  logic [15:0] dmRdData,
  input  logic        dmDone,
  output logic        dmEn,
  output logic        dmWr,
  output logic [15:0] dmAddr,
  output logic [15:0] dmWrData,
  output logic        stall,
  output logic [15:0] aluOut,
  output logic [15:0] memData,
  output logic [15:0] setVal,
  output logic [15:0] nextPcOut,
  output logic        regWrtOut,
  output logic        haltOut,
  output logic        errOut,
  output logic [2:0]  regWrtSrcOut,
  output logic [2:0]  writeRegOut
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // The request cycle is spent in IDLE. The abort therefore fires in the BUSY
  // cycle whose count is TIMEOUT-1, which makes the stall last TIMEOUT cycles.
  localparam logic [3:0] LP_CNT_LAST = 4'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_wr;

  logic        w_req;
  logic        w_misaligned;
  logic        w_done;
  logic        w_abort;
  logic        w_den;
  logic        w_stall;
  logic        w_dm_wr;
  logic [15:0] w_dm_addr;
  logic [15:0] w_dm_wdata;

  logic [15:0] r_alu_out;
  logic [15:0] r_mem_data;
  logic [15:0] r_set_val;
  logic [15:0] r_next_pc;
  logic        r_reg_wrt;
  logic        r_halt_out;
  logic        r_err_out;
  logic [2:0]  r_reg_wrt_src;
  logic [2:0]  r_write_reg;

  // Next-state, request and stall decode for the access FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_req        = 1'b0;
    w_misaligned = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    w_den        = 1'b0;
    w_stall      = 1'b0;
    w_dm_wr      = memWrtIn;
    w_dm_addr    = aluIn;
    w_dm_wdata   = storeData;
    case (r_state)
      ST_IDLE: begin
        // dmDone is ignored here, including in the request cycle itself.
        if (memEnIn) begin
          if (aluIn[0]) begin
            w_misaligned = 1'b1;
          end else if (!r_halt_out) begin
            w_req       = 1'b1;
            w_den       = 1'b1;
            w_stall     = 1'b1;
            w_state_nxt = ST_BUSY;
            w_cnt_nxt   = 4'd0;
          end else begin
            // After a halt, memory instructions pass through without access.
            w_req = 1'b0;
          end
        end else begin
          w_req = 1'b0;
        end
      end
      ST_BUSY: begin
        w_den      = 1'b1;
        w_dm_wr    = r_wr;
        w_dm_addr  = r_addr;
        w_dm_wdata = r_wdata;
        if (dmDone) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_abort     = 1'b1;
          w_den       = 1'b0;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = r_cnt + 4'd1;
        end else begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Gating with rst drops the request and the stall as soon as reset is
  // asserted, without waiting for a clock edge.
  assign dmEn     = w_den & rst;
  assign stall    = w_stall & rst;
  assign dmWr     = w_dm_wr;
  assign dmAddr   = w_dm_addr;
  assign dmWrData = w_dm_wdata;

  // FSM state, wait counter and latched request fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_req) begin
        r_addr  <= aluIn;
        r_wdata <= storeData;
        r_wr    <= memWrtIn;
      end
    end
  end

  // MEM/WB pipeline register. It loads a bubble while stalled and loads the
  // instruction otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_out     <= 16'h0000;
      r_mem_data    <= 16'h0000;
      r_set_val     <= 16'h0000;
      r_next_pc     <= 16'h0000;
      r_reg_wrt     <= 1'b0;
      r_halt_out    <= 1'b0;
      r_err_out     <= 1'b0;
      r_reg_wrt_src <= 3'd0;
      r_write_reg   <= 3'd0;
    end else if (w_stall) begin
      r_reg_wrt  <= 1'b0;
      r_err_out  <= 1'b0;
      // Stalls only occur before a halt, so this keeps haltOut low in bubbles.
      r_halt_out <= r_halt_out;
    end else begin
      r_alu_out     <= aluIn;
      r_set_val     <= setValIn;
      r_next_pc     <= nextPcIn;
      r_reg_wrt_src <= regWrtSrcIn;
      r_write_reg   <= writeRegIn;
      r_reg_wrt     <= regWrtIn & ~w_abort & ~w_misaligned;
      r_err_out     <= errIn | w_abort | w_misaligned;
      r_halt_out    <= r_halt_out | haltIn;
      // Only a completed load returns data. Stores, aborts and non-memory
      // instructions all load zero.
      r_mem_data    <= (w_done && !r_wr) ? dmRdData : 16'h0000;
    end
  end

  assign aluOut       = r_alu_out;
  assign memData      = r_mem_data;
  assign setVal       = r_set_val;
  assign nextPcOut    = r_next_pc;
  assign regWrtOut    = r_reg_wrt;
  assign haltOut      = r_halt_out;
  assign errOut       = r_err_out;
  assign regWrtSrcOut = r_reg_wrt_src;
  assign writeRegOut  = r_write_reg;

endmodule

// File: tb/tb_memory_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_stage
// Directed-vector bench for memory_stage.
//
// - The driver presents one instruction per vector.
// - It pushes the hand-computed MEM/WB contents into a scoreboard queue.
// - It checks the request/stall behaviour cycle by cycle.
// - A separate monitor pops and compares whenever an instruction is accepted,
//   that is, on a clock edge with stall low.
// -----------------------------------------------------------------------------
module tb_memory_stage;

  logic        clk;
  logic        rst;
  logic [15:0] aluIn, storeData, setValIn, nextPcIn, dmRdData;
  logic        memEnIn, memWrtIn, regWrtIn, haltIn, errIn, dmDone;
  logic [2:0]  regWrtSrcIn, writeRegIn;
  logic        dmEn, dmWr, stall, regWrtOut, haltOut, errOut;
  logic [15:0] dmAddr, dmWrData, aluOut, memData, setVal, nextPcOut;
  logic [2:0]  regWrtSrcOut, writeRegOut;

  memory_stage #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .aluIn(aluIn), .storeData(storeData),
    .setValIn(setValIn), .nextPcIn(nextPcIn), .memEnIn(memEnIn),
    .memWrtIn(memWrtIn), .regWrtIn(regWrtIn), .haltIn(haltIn), .errIn(errIn),
    .regWrtSrcIn(regWrtSrcIn), .writeRegIn(writeRegIn), .dmRdData(dmRdData),
    .dmDone(dmDone), .dmEn(dmEn), .dmWr(dmWr), .dmAddr(dmAddr),
    .dmWrData(dmWrData), .stall(stall), .aluOut(aluOut), .memData(memData),
    .setVal(setVal), .nextPcOut(nextPcOut), .regWrtOut(regWrtOut),
    .haltOut(haltOut), .errOut(errOut), .regWrtSrcOut(regWrtSrcOut),
    .writeRegOut(writeRegOut)
  );

  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] mem;
    logic [15:0] sv;
    logic [15:0] np;
    logic        rw;
    logic        h;
    logic        e;
    logic [2:0]  src;
    logic [2:0]  wr;
  } wb_t;

  typedef struct {
    logic [15:0] alu, sd, sv, np, rd;
    logic        me, mw, rw, h, e, early;
    logic [2:0]  src, wr;
    int          done_at;   // cycle index (0 = request cycle) of dmDone; -1 = never
    int          exp_stall;
    logic [15:0] exp_mem;
    logic        exp_rw, exp_h, exp_e;
  } vec_t;

  wb_t  sb_q[$];
  vec_t vecs[10];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic tb_vld = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Scoreboard monitor. An edge with stall low captures the current instruction.
  initial begin
    logic s, v, r;
    wb_t  a, e;
    forever begin
      @(posedge clk);
      s = stall; v = tb_vld; r = rst;
      #1;
      if (r && v && !s) begin
        a = '{aluOut, memData, setVal, nextPcOut, regWrtOut, haltOut, errOut,
              regWrtSrcOut, writeRegOut};
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_empty: DUT captured %0h with no expected entry", a);
        end else begin
          e = sb_q.pop_front();
          chk("wb_out", 128'(a), 128'(e));
        end
      end
    end
  end

  task automatic clear_inputs();
    aluIn = 16'h0000; storeData = 16'h0000; setValIn = 16'h0000; nextPcIn = 16'h0000;
    memEnIn = 1'b0; memWrtIn = 1'b0; regWrtIn = 1'b0; haltIn = 1'b0; errIn = 1'b0;
    regWrtSrcIn = 3'd0; writeRegIn = 3'd0; dmDone = 1'b0; dmRdData = 16'h0000;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int stall_cnt = 0, hold_bad = 0, den_bad = 0, bub_bad = 0;
    logic acc = 1'b0;
    logic [15:0] snap_alu;
    @(negedge clk);
    aluIn = v.alu; storeData = v.sd; setValIn = v.sv; nextPcIn = v.np;
    memEnIn = v.me; memWrtIn = v.mw; regWrtIn = v.rw; haltIn = v.h; errIn = v.e;
    regWrtSrcIn = v.src; writeRegIn = v.wr; tb_vld = 1'b1;
    sb_q.push_back('{v.alu, v.exp_mem, v.sv, v.np, v.exp_rw, v.exp_h, v.exp_e, v.src, v.wr});
    snap_alu = aluOut;
    for (int k = 0; k < 40 && !acc; k++) begin
      if (k > 0) @(negedge clk);
      if (k == v.done_at) begin
        dmDone = 1'b1; dmRdData = v.rd;
      end else if (k == 0 && v.early) begin
        dmDone = 1'b1; dmRdData = 16'hDEAD;
      end else begin
        dmDone = 1'b0; dmRdData = 16'h0000;
      end
      #1;
      // Each earlier cycle of this loop stalled, so the register holds a bubble.
      if (k > 0 && (regWrtOut !== 1'b0 || errOut !== 1'b0 || haltOut !== 1'b0 || aluOut !== snap_alu))
        bub_bad++;
      if (stall) begin
        stall_cnt++;
        if (!(dmEn === 1'b1 && dmAddr === v.alu && dmWr === v.mw && dmWrData === v.sd)) hold_bad++;
      end else begin
        acc = 1'b1;
        if (dmEn === 1'b1 && dmDone === 1'b0) den_bad++;
      end
    end
    if (!acc) begin
      n_chk++;
      $display("FAIL %s_accept: instruction not accepted within 40 cycles", name);
      void'(sb_q.pop_back());
    end
    @(negedge clk);
    clear_inputs();
    tb_vld = 1'b0;
    chk({name, "_stall_cycles"}, 128'(stall_cnt), 128'(v.exp_stall));
    chk({name, "_dm_hold_bad"}, 128'(hold_bad), 128'd0);
    chk({name, "_dmen_unstalled_bad"}, 128'(den_bad), 128'd0);
    chk({name, "_bubble_bad"}, 128'(bub_bad), 128'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            alu      sd       sv       np       rd       me   mw   rw   h    e    early src  wr  done stall exp_mem  rw   h    e
    vecs[0] = '{16'h1234,16'h0000,16'h5555,16'h0002,16'h0000,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,3'd1,3'd3, -1, 0, 16'h0000,1'b1,1'b0,1'b0};
    vecs[1] = '{16'h0040,16'h0000,16'h0001,16'h0004,16'hBEEF,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,3'd2,3'd5,  3, 3, 16'hBEEF,1'b1,1'b0,1'b0};
    vecs[2] = '{16'h0010,16'h00AA,16'h0002,16'h0006,16'h1111,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,  2, 2, 16'h0000,1'b0,1'b0,1'b0};
    vecs[3] = '{16'h0041,16'h0000,16'h0003,16'h0008,16'h2222,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,3'd2,3'd2, -1, 0, 16'h0000,1'b0,1'b0,1'b1};
    vecs[4] = '{16'h0020,16'h0000,16'h0004,16'h000A,16'h3333,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,3'd2,3'd4, -1,15, 16'h0000,1'b0,1'b0,1'b1};
    vecs[5] = '{16'h0030,16'h0000,16'h0005,16'h000C,16'hCAFE,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,3'd2,3'd6,  1, 1, 16'hCAFE,1'b1,1'b0,1'b0};
    vecs[6] = '{16'hFFFF,16'h0000,16'h0006,16'h000E,16'h0000,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,3'd7,3'd7, -1, 0, 16'h0000,1'b1,1'b0,1'b1};
    vecs[7] = '{16'h0082,16'h0000,16'h0007,16'h0010,16'h2468,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,3'd2,3'd1,  2, 2, 16'h2468,1'b1,1'b0,1'b0};
    vecs[8] = '{16'h00AB,16'h0000,16'h0008,16'h0012,16'h0000,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,3'd1,3'd1, -1, 0, 16'h0000,1'b1,1'b1,1'b0};
    vecs[9] = '{16'h0050,16'h0000,16'h0009,16'h0014,16'h4444,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,3'd2,3'd3, -1, 0, 16'h0000,1'b1,1'b1,1'b0};

    // Reset with an aligned load presented: the request must stay masked.
    clear_inputs();
    rst = 1'b0;
    memEnIn = 1'b1; aluIn = 16'h0004;
    #3;
    chk("reset_state",
        128'({dmEn, stall, aluOut, memData, setVal, nextPcOut, regWrtOut, haltOut,
              errOut, regWrtSrcOut, writeRegOut}), 128'd0);
    clear_inputs();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    run_vec(vecs[0], "alu_op");
    run_vec(vecs[1], "load_beef");
    run_vec(vecs[2], "store_aa");
    run_vec(vecs[3], "misaligned");
    run_vec(vecs[4], "timeout");
    run_vec(vecs[5], "early_done");
    run_vec(vecs[6], "nonmem_err");

    // Reset pulsed in the second BUSY cycle. The bench does not score this load.
    @(negedge clk);
    aluIn = 16'h7777; setValIn = 16'h0077; nextPcIn = 16'h0078; regWrtIn = 1'b1;
    errIn = 1'b1; writeRegIn = 3'd3; regWrtSrcIn = 3'd2;
    @(negedge clk);
    aluIn = 16'h0080; memEnIn = 1'b1; errIn = 1'b0;
    @(negedge clk);
    chk("pre_rst_alu_hold", 128'(aluOut), 128'h7777);
    @(negedge clk);
    chk("pre_rst_busy_den", 128'(dmEn), 128'd1);
    rst = 1'b0;
    #1;
    chk("rst_async_clear",
        128'({dmEn, stall, aluOut, memData, setVal, nextPcOut, regWrtOut, haltOut,
              errOut, regWrtSrcOut, writeRegOut}), 128'd0);
    clear_inputs();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    run_vec(vecs[7], "post_rst_load");
    run_vec(vecs[8], "halt");
    run_vec(vecs[9], "load_after_halt");

    @(negedge clk); @(negedge clk);
    chk("halt_sticky", 128'(haltOut), 128'd1);
    chk("sb_drained", 128'(sb_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
